// File: rtl/sparc_fetch_unit_if.sv
// sparc_fetch_unit_if: fetch-stage control, memory and IF/ID bus bundle.
// Carries misalign_trap only when IF_MISALIGN_TRAP_EN is defined.
interface sparc_fetch_unit_if;
    logic        LE;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        annul;
    logic [31:0] imem_addr;
    logic [31:0] PC_IF;
    logic [31:0] nPC_IF;
    logic [31:0] instruction_IF;
    logic        IF_ID_LE;
    logic        IF_ID_clr;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_trap;
    modport master (
        output LE, imem_ready, imem_data, branch_taken, branch_target, annul,
        input  imem_addr, PC_IF, nPC_IF, instruction_IF, IF_ID_LE, IF_ID_clr, misalign_trap
    );
    modport slave (
        input  LE, imem_ready, imem_data, branch_taken, branch_target, annul,
        output imem_addr, PC_IF, nPC_IF, instruction_IF, IF_ID_LE, IF_ID_clr, misalign_trap
    );
`else
    modport master (
        output LE, imem_ready, imem_data, branch_taken, branch_target, annul,
        input  imem_addr, PC_IF, nPC_IF, instruction_IF, IF_ID_LE, IF_ID_clr
    );
    modport slave (
        input  LE, imem_ready, imem_data, branch_taken, branch_target, annul,
        output imem_addr, PC_IF, nPC_IF, instruction_IF, IF_ID_LE, IF_ID_clr
    );
`endif
endinterface

// File: rtl/sparc_fetch_unit.sv
// sparc_fetch_unit: SPARC IF stage with PC/nPC, delayed branching and imem wait-state FSM.
// IF_MISALIGN_TRAP_EN enables the sticky misaligned-redirect trap.
module sparc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic reset,
    sparc_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;
    state_t state, state_nx;
    logic [31:0] pc, npc, pc_if, ins, pend_target, tgt, redir_tgt, pc_next;
    logic pend_valid, pend_annul, redir, redir_annul, bad, trap;
    logic if_id_le, if_id_clr, issue, advance, capture, set_trap;

`ifdef IF_MISALIGN_TRAP_EN
    assign tgt = bus.branch_target;
    assign bad = redir && (redir_tgt[1:0] != 2'b00);
    always_ff @(posedge clk or negedge reset)
        if (!reset) trap <= 1'b0;
        else if (set_trap) trap <= 1'b1;
    assign bus.misalign_trap = trap;
`else
    assign tgt = {bus.branch_target[31:2], 2'b00};
    assign bad = 1'b0;
    assign trap = 1'b0;
`endif

    // A live branch_taken wins over a recorded one; pend is only ever set while waiting
    assign redir       = bus.branch_taken | pend_valid;
    assign redir_tgt   = bus.branch_taken ? tgt : pend_target;
    assign redir_annul = bus.branch_taken ? bus.annul : pend_annul;
    assign pc_next     = redir ? redir_tgt : npc;

    always_comb begin
        state_nx  = state;
        if_id_le  = 1'b1;
        if_id_clr = 1'b0;
        issue     = 1'b0;
        advance   = 1'b0;
        capture   = 1'b0;
        set_trap  = 1'b0;
        if (state == BOOT) begin
            if_id_le  = 1'b0;
            if_id_clr = 1'b1;
            state_nx  = RUN;
        end else if (trap) begin
            if_id_le  = bus.LE;
            if_id_clr = 1'b1;
        end else if (!bus.LE) begin
            if_id_le = 1'b0;
        end else if (!bus.imem_ready) begin
            if_id_clr = 1'b1;
            capture   = bus.branch_taken;
            state_nx  = WAIT;
        end else begin
            issue     = 1'b1;
            if_id_clr = redir & redir_annul;
            set_trap  = bad;
            advance   = !bad;
            state_nx  = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            npc         <= RESET_PC + 32'd4;
            pc_if       <= 32'd0;
            ins         <= 32'd0;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            pend_annul  <= 1'b0;
        end else begin
            state <= state_nx;
            if (issue) begin
                pc_if <= pc;
                ins   <= bus.imem_data;
            end
            if (advance) begin
                pc  <= pc_next;
                npc <= pc_next + 32'd4;
            end
            if (capture) begin
                pend_valid  <= 1'b1;
                pend_target <= tgt;
                pend_annul  <= bus.annul;
            end else if (issue) pend_valid <= 1'b0;
        end

    assign bus.imem_addr      = pc;
    assign bus.PC_IF          = pc_if;
    assign bus.nPC_IF         = npc;
    assign bus.instruction_IF = ins;
    assign bus.IF_ID_LE       = if_id_le;
    assign bus.IF_ID_clr      = if_id_clr;
endmodule

// File: tb/tb_sparc_fetch_unit.sv
// tb_sparc_fetch_unit: directed scenarios plus randomized run against an issue-stream model.
module tb_sparc_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    sparc_fetch_unit_if bus();
    sparc_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction
    assign bus.imem_data = mem(bus.imem_addr);

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc, m_npc, m_pc_if, m_ins, m_ptgt;
    logic m_boot, m_pend, m_pann, m_trap;
    logic [31:0] e_addr, o_addr;
    logic e_le, e_clr, o_le, o_clr;

    // One cycle: apply inputs, sample combinational outputs mid-cycle, advance model and clock
    task automatic drive(input logic le, input logic rdy, input logic bt, input logic [31:0] tgt, input logic an);
        logic [31:0] t;
        logic r, a;
        bus.LE = le; bus.imem_ready = rdy; bus.branch_taken = bt; bus.branch_target = tgt; bus.annul = an;
        #2;
        o_addr = bus.imem_addr; o_le = bus.IF_ID_LE; o_clr = bus.IF_ID_clr;
        e_addr = m_pc;
        r = bt | m_pend;
        t = bt ? tgt : m_ptgt;
        a = bt ? an : m_pann;
`ifndef IF_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        if (m_boot) begin e_le = 0; e_clr = 1; m_boot = 0; end
        else if (m_trap) begin e_le = le; e_clr = 1; end
        else if (!le) begin e_le = 0; e_clr = 0; end
        else if (!rdy) begin
            e_le = 1; e_clr = 1;
            if (bt) begin m_pend = 1; m_ptgt = t; m_pann = an; end
        end else begin
            e_le = 1; e_clr = r & a;
            m_pc_if = m_pc; m_ins = mem(m_pc); m_pend = 0;
            if (r && t[1:0] != 2'b00) m_trap = 1;
            else begin m_pc = r ? t : m_npc; m_npc = m_pc + 32'd4; end
        end
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        m_pc = 0; m_npc = 4; m_pc_if = 0; m_ins = 0; m_ptgt = 0;
        m_boot = 1; m_pend = 0; m_pann = 0; m_trap = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        model_reset();
    endtask

    task automatic test_reset();
        bus.LE = 1; bus.imem_ready = 1; bus.branch_taken = 0; bus.branch_target = 0; bus.annul = 0;
        #1 reset = 0;
        @(posedge clk); #1;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.imem_addr); end
        checks++; if (bus.nPC_IF !== 32'h4) begin errors++; $display("FAIL rst_npc got %h exp 4", bus.nPC_IF); end
        checks++; if (bus.PC_IF !== 32'h0) begin errors++; $display("FAIL rst_pc_if got %h exp 0", bus.PC_IF); end
        checks++; if (bus.instruction_IF !== 32'h0) begin errors++; $display("FAIL rst_ins got %h exp 0", bus.instruction_IF); end
        checks++; if (bus.IF_ID_LE !== 1'b0) begin errors++; $display("FAIL rst_le got %b exp 0", bus.IF_ID_LE); end
        checks++; if (bus.IF_ID_clr !== 1'b1) begin errors++; $display("FAIL rst_clr got %b exp 1", bus.IF_ID_clr); end
        reset = 1;
        model_reset();
        drive(1, 1, 0, 0, 0);
        checks++; if (o_le !== 1'b0 || o_clr !== 1'b1) begin errors++; $display("FAIL boot_bubble got le=%b clr=%b exp le=0 clr=1", o_le, o_clr); end
        checks++; if (bus.PC_IF !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL boot_hold got pc_if=%h addr=%h exp 0 0", bus.PC_IF, bus.imem_addr); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 0, 0);
            checks++; if (o_addr !== 32'(4 * k) || o_le !== 1'b1 || o_clr !== 1'b0) begin errors++; $display("FAIL seq_fetch k=%0d got addr=%h le=%b clr=%b exp %h 1 0", k, o_addr, o_le, o_clr, 4 * k); end
            checks++; if (bus.PC_IF !== 32'(4 * k) || bus.instruction_IF !== mem(32'(4 * k))) begin errors++; $display("FAIL seq_issue k=%0d got pc=%h ins=%h exp %h %h", k, bus.PC_IF, bus.instruction_IF, 4 * k, mem(32'(4 * k))); end
            checks++; if (bus.nPC_IF !== 32'(4 * k + 8)) begin errors++; $display("FAIL seq_npc k=%0d got %h exp %h", k, bus.nPC_IF, 4 * k + 8); end
        end
    endtask

    task automatic test_branch(input logic an);
        do_reset();
        drive(1, 1, 0, 0, 0);
        repeat (3) drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 32'h100, an);
        checks++; if (o_addr !== 32'hC || o_clr !== an) begin errors++; $display("FAIL br_slot an=%b got addr=%h clr=%b exp c %b", an, o_addr, o_clr, an); end
        checks++; if (bus.PC_IF !== 32'hC) begin errors++; $display("FAIL br_slot_pc an=%b got %h exp c", an, bus.PC_IF); end
        drive(1, 1, 0, 0, 0);
        checks++; if (o_addr !== 32'h100 || bus.PC_IF !== 32'h100 || bus.nPC_IF !== 32'h108) begin errors++; $display("FAIL br_target an=%b got addr=%h pc=%h npc=%h exp 100 100 108", an, o_addr, bus.PC_IF, bus.nPC_IF); end
        drive(1, 1, 0, 0, 0);
        checks++; if (bus.PC_IF !== 32'h104 || o_clr !== 1'b0) begin errors++; $display("FAIL br_after an=%b got pc=%h clr=%b exp 104 0", an, bus.PC_IF, o_clr); end
    endtask

    task automatic test_wait();
        do_reset();
        drive(1, 1, 0, 0, 0);
        repeat (2) drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 32'h40, 0);
        checks++; if (o_le !== 1'b1 || o_clr !== 1'b1 || bus.PC_IF !== 32'h4) begin errors++; $display("FAIL wait_b1 got le=%b clr=%b pc=%h exp 1 1 4", o_le, o_clr, bus.PC_IF); end
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 0);
            checks++; if (o_le !== 1'b1 || o_clr !== 1'b1 || bus.PC_IF !== 32'h4 || o_addr !== 32'h8) begin errors++; $display("FAIL wait_bubble k=%0d got le=%b clr=%b pc=%h addr=%h exp 1 1 4 8", k, o_le, o_clr, bus.PC_IF, o_addr); end
        end
        drive(1, 1, 0, 0, 0);
        checks++; if (o_addr !== 32'h8 || o_clr !== 1'b0 || bus.PC_IF !== 32'h8 || bus.instruction_IF !== mem(32'h8)) begin errors++; $display("FAIL wait_issue got addr=%h clr=%b pc=%h exp 8 0 8", o_addr, o_clr, bus.PC_IF); end
        drive(1, 1, 0, 0, 0);
        checks++; if (o_addr !== 32'h40 || bus.PC_IF !== 32'h40) begin errors++; $display("FAIL wait_redirect got addr=%h pc=%h exp 40 40", o_addr, bus.PC_IF); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 32'h200, 1);
            checks++; if (o_le !== 1'b0 || bus.PC_IF !== 32'h40 || bus.instruction_IF !== mem(32'h40)) begin errors++; $display("FAIL stall_hold k=%0d got le=%b pc=%h exp 0 40", k, o_le, bus.PC_IF); end
        end
        drive(1, 1, 0, 0, 0);
        checks++; if (o_addr !== 32'h44 || bus.PC_IF !== 32'h44) begin errors++; $display("FAIL stall_resume got addr=%h pc=%h exp 44 44", o_addr, bus.PC_IF); end
    endtask

    task automatic test_reset_mid_wait();
        drive(1, 0, 1, 32'h300, 1);
        reset = 0;
        #1;
        checks++; if (bus.imem_addr !== 32'h0 || bus.PC_IF !== 32'h0) begin errors++; $display("FAIL async_rst got addr=%h pc=%h exp 0 0", bus.imem_addr, bus.PC_IF); end
        @(posedge clk); #1;
        reset = 1;
        model_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        checks++; if (bus.PC_IF !== 32'h0 || o_clr !== 1'b0) begin errors++; $display("FAIL rstwait_first got pc=%h clr=%b exp 0 0", bus.PC_IF, o_clr); end
        drive(1, 1, 0, 0, 0);
        checks++; if (bus.PC_IF !== 32'h4) begin errors++; $display("FAIL rstwait_pend_dropped got %h exp 4", bus.PC_IF); end
    endtask

    task automatic test_wrap();
        drive(1, 1, 1, 32'hFFFF_FFFC, 0);
        checks++; if (bus.PC_IF !== 32'h8) begin errors++; $display("FAIL wrap_slot got %h exp 8", bus.PC_IF); end
        drive(1, 1, 0, 0, 0);
        checks++; if (bus.PC_IF !== 32'hFFFF_FFFC || bus.nPC_IF !== 32'h4) begin errors++; $display("FAIL wrap_edge got pc=%h npc=%h exp fffffffc 4", bus.PC_IF, bus.nPC_IF); end
        drive(1, 1, 0, 0, 0);
        checks++; if (bus.PC_IF !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", bus.PC_IF); end
    endtask

    task automatic test_misalign();
        drive(1, 1, 1, 32'h102, 0);
        checks++; if (bus.PC_IF !== 32'h4) begin errors++; $display("FAIL mis_slot got %h exp 4", bus.PC_IF); end
`ifdef IF_MISALIGN_TRAP_EN
        checks++; if (bus.misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_trap got %b exp 1", bus.misalign_trap); end
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 0);
            checks++; if (o_clr !== 1'b1 || bus.PC_IF !== 32'h4 || o_addr !== 32'h4 || bus.misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_bubble k=%0d got clr=%b pc=%h addr=%h exp 1 4 4", k, o_clr, bus.PC_IF, o_addr); end
        end
`else
        drive(1, 1, 0, 0, 0);
        checks++; if (o_addr !== 32'h100 || bus.PC_IF !== 32'h100) begin errors++; $display("FAIL mis_forced got addr=%h pc=%h exp 100 100", o_addr, bus.PC_IF); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] t;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            t = $urandom;
`ifdef IF_MISALIGN_TRAP_EN
            t[1:0] = 2'b00;
`endif
            drive(logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 6) == 0), t, logic'($urandom_range(0, 1)));
            checks++; if (o_addr !== e_addr) begin errors++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, o_addr, e_addr); end
            checks++; if (o_le !== e_le || o_clr !== e_clr) begin errors++; $display("FAIL rnd_ctl c=%0d got le=%b clr=%b exp %b %b", c, o_le, o_clr, e_le, e_clr); end
            checks++; if (bus.PC_IF !== m_pc_if || bus.instruction_IF !== m_ins) begin errors++; $display("FAIL rnd_issue c=%0d got pc=%h ins=%h exp %h %h", c, bus.PC_IF, bus.instruction_IF, m_pc_if, m_ins); end
            checks++; if (bus.nPC_IF !== m_npc) begin errors++; $display("FAIL rnd_npc c=%0d got %h exp %h", c, bus.nPC_IF, m_npc); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch(1'b0);
        test_branch(1'b1);
        test_wait();
        test_stall();
        test_reset_mid_wait();
        test_wrap();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sparc_fetch_unit.md
# sparc_fetch_unit

Instruction Fetch stage of the SPARC pipeline: owns the PC/nPC register pair, drives the instruction-memory address, and presents the fetched word, its PC, and the load-enable/clear controls to the IF/ID pipeline register. It implements SPARC delayed branching: the delay slot is always fetched; it is squashed only when an annulling branch requests it. A small FSM absorbs instruction-memory wait states and records a branch redirect that arrives mid-wait.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; nPC resets to RESET_PC+4
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- LE  in  1  stage load enable from hazard unit; 0 = hold PC/nPC and outputs
- imem_ready  in  1  instruction memory has valid data for imem_addr this cycle
- imem_data  in  32  instruction word at imem_addr
- branch_taken  in  1  ID-stage condition handler: redirect to branch_target
- branch_target  in  32  redirect address
- annul  in  1  squash the delay-slot instruction (SPARC a-bit semantics, already resolved by ID)
- imem_addr  out  32  current PC, combinational
- PC_IF  out  32  PC of the word on instruction_IF
- nPC_IF  out  32  nPC register
- instruction_IF  out  32  fetched word
- IF_ID_LE  out  1  load enable for IF/ID register
- IF_ID_clr  out  1  clear (bubble) for IF/ID register
- misalign_trap  out  1  sticky flag; present only with IF_MISALIGN_TRAP_EN

## Operation
- States: BOOT, RUN, WAIT. Reset to BOOT.
- Reset values: PC=RESET_PC, nPC=RESET_PC+4, PC_IF=0, instruction_IF=0, IF_ID_LE=0, IF_ID_clr=1, pend_valid=0, pend_annul=0, misalign_trap=0.
- BOOT: one cycle after reset deassertion; IF_ID_clr=1; unconditionally -> RUN.
- RUN, LE=1, imem_ready=1: PC_IF<=PC, instruction_IF<=imem_data, PC<=nPC, nPC<=nPC+4; IF_ID_LE=1, IF_ID_clr=0.
- RUN, LE=1, branch_taken=1: PC<=branch_target, nPC<=branch_target+4 (overrides sequential update). Word fetched this cycle (delay slot) still issues; if annul=1 it issues with IF_ID_clr=1.
- RUN, LE=0: PC, nPC, state held; IF_ID_LE=0; branch_taken/annul ignored (hazard unit guarantees no resolution while stalled).
- RUN, LE=1, imem_ready=0: -> WAIT; PC/nPC held; IF_ID_LE=1, IF_ID_clr=1 (bubble). If branch_taken=1 same cycle: pend_valid<=1, pend_target<=branch_target, pend_annul<=annul.
- WAIT: bubble each cycle while imem_ready=0; a branch_taken arriving in WAIT is recorded in pend (second arrival while pend_valid=1 is illegal; newer overwrites).
- WAIT, imem_ready=1, LE=1: issue word as RUN; if pend_valid: PC<=pend_target, nPC<=pend_target+4, IF_ID_clr=pend_annul, pend_valid<=0; -> RUN.
- Priority: reset > LE=0 hold > redirect > sequential.
- Arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Reset asserted mid-WAIT discards pending redirect.

## Timing
- imem_addr is combinational from PC register; memory is expected to return same cycle when imem_ready=1.
- Fetch-to-IF/ID latency: 1 cycle (registered on the clk edge where imem_ready=1 and LE=1).
- Redirect penalty: 0 bubbles beyond the architectural delay slot; target fetched the cycle after branch_taken.
- IF_ID_LE and IF_ID_clr are combinational from state, LE, imem_ready, annul, pend.

## Configuration
- IF_MISALIGN_TRAP_EN defined: redirect with branch_target[1:0]!=0 sets misalign_trap (sticky until reset), PC/nPC not updated, all following cycles issue bubbles.
- Undefined: branch_target[1:0] forced to 2'b00; misalign_trap port absent.

## Test plan
- Reset release, imem_ready=1, LE=1: BOOT bubble, then PC_IF 0,4,8,... with instruction_IF = memory contents.
- branch_taken at PC=8 (delay slot at C), target 0x100, annul=0: issued PCs 8,C,100,104.
- Same with annul=1: word at C issues with IF_ID_clr=1; next PC_IF = 0x100.
- imem_ready low 3 cycles with branch_taken (target 0x40) in first wait cycle: 3 bubbles, waited word issues, next fetch 0x40.
- LE=0 for 2 cycles: PC_IF/instruction_IF unchanged, IF_ID_LE=0, branch_taken ignored.
- With IF_MISALIGN_TRAP_EN, target 0x102: misalign_trap=1 next cycle, only bubbles thereafter; without macro, fetch resumes at 0x100.
